csr_file: RTL and testbench
===========================

# csr_file

Parametrised machine-mode control and status register unit for the rv32i data path, succeeding the fixed-width CSR bank. Decodes standard RISC-V CSR addresses, executes CSRRW/CSRRS/CSRRC, sequences trap entry and MRET, synchronises and masks external interrupt lines, and keeps wrapping cycle and instret counters. It sits beside the register file: the decode stage drives the access port, and the fetch stage consumes `trap_take`/`trap_pc`.

## Interface
- `XLEN`, 32: data width of every CSR.
- `NUM_IRQ`, 4: external interrupt lines, 1..16; mapped to mip/mie bits 16+i.
- `CNT_WIDTH`, 64: counter width, XLEN < CNT_WIDTH ≤ 2·XLEN.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `csr_en` in 1: CSR instruction valid this cycle.
- `csr_op` in 2: 01 RW, 10 RS, 11 RC; 00 is a read only.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in XLEN: rs1 value or zimm.
- `csr_rdata` out XLEN: old CSR value, combinational.
- `csr_illegal` out 1: access is illegal, combinational.
- `instr_retire` in 1: one instruction retired.
- `except` in 1: synchronous exception.
- `except_cause` in 5: exception code.
- `except_pc` in XLEN: pc of the faulting instruction.
- `except_tval` in XLEN: trap value.
- `next_pc` in XLEN: pc saved as mepc when an interrupt is taken.
- `mret` in 1: MRET executing.
- `irq` in NUM_IRQ: asynchronous interrupt lines.
- `trap_take` out 1: redirect fetch to `trap_pc`.
- `trap_pc` out XLEN: redirect target.

## Operation
- **Implemented CSRs:**
  - mstatus 0x300: MIE bit 3, MPIE bit 7; MPP bits 12:11 read 2'b11; all other bits 0.
  - mie 0x304.
  - mtvec 0x305: bit 1 hardwired to 0; mode = bit 0, 0 direct, 1 vectored.
  - mscratch 0x340.
  - mepc 0x341: bits 1:0 forced to 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
- **Illegal accesses:**
  - Any other address is illegal.
  - A write (op≠00) to a read-only address (mip, or addr[11:10]==2'b11) is illegal.
  - An illegal access changes no state.
- **Write value:**
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata==0 perform no write.
- **Interrupts:**
  - `irq` passes through a 2-flop synchroniser into mip[16+i].
  - Interrupt pending = mstatus.MIE & |(mip & mie).
  - The lowest pending index wins; its cause is {1'b1, 16+i}.
- **Trap entry** (exception, or pending interrupt with `instr_retire`==1):
  - mepc ← except_pc (exception) or next_pc (interrupt).
  - mcause ← {interrupt flag, zero-extended code}.
  - mtval ← except_tval, or 0 for an interrupt.
  - MPIE ← MIE, then MIE ← 0.
- **MRET:** MIE ← MPIE, MPIE ← 1; `trap_pc` = mepc.
- **`trap_pc` on trap entry:**
  - Direct mode: mtvec base.
  - Vectored mode, interrupt: base + 4·code.
  - Vectored mode, exception: base.
- **Priority when events coincide:** except > interrupt > mret > CSR write. Lower-priority writes in that cycle are dropped.
- **Counters:**
  - mcycle increments every cycle; minstret increments on `instr_retire`.
  - A CSR write to either half in the same cycle wins over the increment; the other half keeps its value and does not increment.
  - Both counters wrap to 0 on all-ones.
  - High halves return bits CNT_WIDTH-1:XLEN, zero-extended.

## Timing
- `csr_rdata`, `csr_illegal`, `trap_take` and `trap_pc` are combinational in the same cycle.
- State updates on the next rising `clk` edge.
- An irq line reaches mip 2 cycles after it rises. A trap can be taken in cycle 3 at the earliest.
- After trap entry MIE=0, so no nested interrupt is taken.
- **Reset** (asynchronous on `rst_n`=0):
  - All CSRs, counters and synchroniser flops are cleared.
  - `csr_rdata`=0, `csr_illegal`=0, `trap_take`=0, `trap_pc`=0.
  - The counters restart at 0 on the first edge after release.
  - If reset asserts mid-trap, the trap is lost. No partial update is allowed.

## Structure
- **Package `csr_pkg`:**
  - CSR address constants.
  - csr_op encodings.
  - mstatus bit positions (MIE=3, MPIE=7).
  - Interrupt base index 16 and exception code constants.
- **Sub-module `csr_counter`:**
  - Parameter CNT_WIDTH.
  - Inputs: inc, wr_lo, wr_hi, wdata.
  - Instantiated twice, for mcycle and minstret.

## Test plan
- Reset → mtvec=0x100 (RW) → except, cause=2, pc=0x40, tval=0xDEAD:
  - `trap_pc`=0x100.
  - mepc=0x40, mcause=2, mtval=0xDEAD, MIE=0.
- Vectored interrupt: mtvec=0x201, mie[16]=1, MIE=1, raise irq[0]:
  - `trap_take` follows the 3rd retire after irq rises.
  - `trap_pc`=0x200+4·16=0x240; mcause=0x80000010.
- MRET after that trap:
  - `trap_pc`=saved next_pc; MIE=1, MPIE=1.
- CSR ops on mscratch=0xF0:
  - RS 0x0F → rdata 0xF0, then reads 0xFF.
  - RC 0xF0 → 0x0F.
  - RS 0 → no write.
  - Write to mip → `csr_illegal`=1, state unchanged.
- Counters:
  - Write mcycle=0xFFFFFFFF, mcycleh=0xFFFFFFFF → next cycle wraps to 0.
  - Write minstret while retiring → written value held, no +1.
- Simultaneous events:
  - except and CSR write to mscratch in the same cycle → mscratch unchanged.
  - `rst_n` pulsed mid-trap → all outputs 0 asynchronously.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, access
// opcodes, mstatus bit positions, interrupt base index and exception codes.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    // External line i appears at mip/mie bit IRQ_BASE+i and traps with code IRQ_BASE+i.
    localparam int unsigned IRQ_BASE = 16;

    localparam logic [4:0] EXC_ILLEGAL_INSTR = 5'd2;
    localparam logic [4:0] EXC_STORE_FAULT   = 5'd7;

endpackage

// File: rtl/csr_if.sv
// CSR access port between the decode stage (master) and the CSR unit (slave).
//   csr_en/csr_op/csr_addr/csr_wdata : request from decode
//   csr_rdata/csr_illegal            : same-cycle response
interface csr_if #(
    parameter int unsigned XLEN = 32
);
    logic            csr_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_en, csr_op, csr_addr, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_en, csr_op, csr_addr, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_counter.sv
// Wrapping counter with independently writable low/high halves.
//   inc   : advance by one this cycle
//   wr_lo : load bits XLEN-1:0 from wdata (other half holds, no increment)
//   wr_hi : load bits CNT_WIDTH-1:XLEN from wdata (other half holds, no increment)
//   cnt   : current count
module csr_counter #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [XLEN-1:0]      wdata,
    output logic [CNT_WIDTH-1:0] cnt
);
    localparam int unsigned HI_W = CNT_WIDTH - XLEN;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // A CSR write replaces the increment for the whole counter in that cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo) begin
            cnt_d[XLEN-1:0] = wdata;
        end else if (wr_hi) begin
            cnt_d[CNT_WIDTH-1:XLEN] = wdata[HI_W-1:0];
        end else if (inc) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR unit: CSR decode and CSRRW/CSRRS/CSRRC, trap entry and
// MRET sequencing, interrupt synchronisation/masking, mcycle/minstret.
//   bus           : CSR access port (combinational rdata/illegal)
//   instr_retire  : one instruction retired; interrupts are taken on retire
//   except*       : synchronous exception with cause, pc and trap value
//   next_pc       : pc saved in mepc for an interrupt
//   mret          : MRET executing
//   irq           : asynchronous interrupt lines
//   trap_take/pc  : combinational fetch redirect
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_IRQ   = 4,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    csr_if.slave               bus,
    input  logic               instr_retire,
    input  logic               except,
    input  logic [4:0]         except_cause,
    input  logic [XLEN-1:0]    except_pc,
    input  logic [XLEN-1:0]    except_tval,
    input  logic [XLEN-1:0]    next_pc,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               trap_take,
    output logic [XLEN-1:0]    trap_pc
);
    logic [NUM_IRQ-1:0] irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d;
    logic               mstatus_mie_q, mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
    logic [XLEN-1:0]    mtvec_q, mtvec_d;
    logic [XLEN-1:0]    mscratch_q, mscratch_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d;
    logic [XLEN-1:0]    mtval_q, mtval_d;

    logic [CNT_WIDTH-1:0] mcycle, minstret;
    logic [XLEN-1:0]      mstatus_val, mie_val, mip_val, mtvec_base;
    logic [XLEN-1:0]      old_val, wval;
    logic                 addr_ok, addr_ro, is_write, illegal, do_wr;
    logic [NUM_IRQ-1:0]   irq_hit;
    logic                 irq_pend;
    logic [4:0]           irq_code;
    logic                 take_exc, take_irq, take_mret, trap_entry;
    logic                 cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

    // Architectural views of the packed state.
    always_comb begin
        mstatus_val               = '0;
        mstatus_val[12:11]        = 2'b11;
        mstatus_val[MSTATUS_MIE]  = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE] = mstatus_mpie_q;
        mie_val                   = '0;
        mie_val[IRQ_BASE +: NUM_IRQ] = mie_en_q;
        mip_val                   = '0;
        mip_val[IRQ_BASE +: NUM_IRQ] = irq_s2_q;
        mtvec_base                = {mtvec_q[XLEN-1:2], 2'b00};
    end

    // Address decode and old-value mux.
    always_comb begin
        old_val = '0;
        addr_ok = 1'b1;
        addr_ro = (bus.csr_addr[11:10] == 2'b11);
        case (bus.csr_addr)
            ADDR_MSTATUS:   old_val = mstatus_val;
            ADDR_MIE:       old_val = mie_val;
            ADDR_MTVEC:     old_val = mtvec_q;
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = mepc_q;
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MTVAL:     old_val = mtval_q;
            ADDR_MIP: begin
                old_val = mip_val;
                addr_ro = 1'b1;
            end
            ADDR_MCYCLE:    old_val = mcycle[XLEN-1:0];
            ADDR_MCYCLEH:   old_val = XLEN'(mcycle >> XLEN);
            ADDR_MINSTRET:  old_val = minstret[XLEN-1:0];
            ADDR_MINSTRETH: old_val = XLEN'(minstret >> XLEN);
            default:        addr_ok = 1'b0;
        endcase
    end

    // Interrupt selection: lowest enabled pending line wins.
    always_comb begin
        irq_hit  = irq_s2_q & mie_en_q;
        irq_pend = mstatus_mie_q && (|irq_hit);
        irq_code = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_hit[i]) irq_code = 5'(int'(IRQ_BASE) + i);
        end
    end

    // Event priority: exception > interrupt > mret > CSR write.
    always_comb begin
        take_exc   = except;
        take_irq   = !except && irq_pend && instr_retire;
        take_mret  = !except && !take_irq && mret;
        trap_entry = take_exc || take_irq;

        is_write = bus.csr_en && (bus.csr_op != CSR_OP_READ);
        illegal  = bus.csr_en && (!addr_ok || (is_write && addr_ro));

        case (bus.csr_op)
            CSR_OP_RW: wval = bus.csr_wdata;
            CSR_OP_RS: wval = old_val | bus.csr_wdata;
            CSR_OP_RC: wval = old_val & ~bus.csr_wdata;
            default:   wval = old_val;
        endcase

        // Set/clear with a zero mask is a pure read.
        do_wr = is_write && !illegal && !trap_entry && !take_mret &&
                !((bus.csr_op != CSR_OP_RW) && (bus.csr_wdata == '0));

        cyc_wr_lo = do_wr && (bus.csr_addr == ADDR_MCYCLE);
        cyc_wr_hi = do_wr && (bus.csr_addr == ADDR_MCYCLEH);
        ins_wr_lo = do_wr && (bus.csr_addr == ADDR_MINSTRET);
        ins_wr_hi = do_wr && (bus.csr_addr == ADDR_MINSTRETH);
    end

    // Combinational responses; forced quiet while reset is asserted.
    always_comb begin
        bus.csr_rdata   = '0;
        bus.csr_illegal = 1'b0;
        trap_take       = 1'b0;
        trap_pc         = '0;
        if (rst_n) begin
            bus.csr_illegal = illegal;
            if (bus.csr_en && !illegal) bus.csr_rdata = old_val;
            trap_take = trap_entry || take_mret;
            if (take_exc) begin
                trap_pc = mtvec_base;
            end else if (take_irq) begin
                trap_pc = mtvec_q[0] ? mtvec_base + XLEN'({irq_code, 2'b00}) : mtvec_base;
            end else if (take_mret) begin
                trap_pc = mepc_q;
            end
        end
    end

    // Next-state for synchroniser and CSR registers.
    always_comb begin
        irq_s1_d       = irq;
        irq_s2_d       = irq_s1_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_en_d       = mie_en_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (trap_entry) begin
            mepc_d             = take_exc ? {except_pc[XLEN-1:2], 2'b00} : {next_pc[XLEN-1:2], 2'b00};
            mcause_d           = XLEN'(take_exc ? except_cause : irq_code);
            mcause_d[XLEN-1]   = take_irq;
            mtval_d            = take_exc ? except_tval : '0;
            mstatus_mpie_d     = mstatus_mie_q;
            mstatus_mie_d      = 1'b0;
        end else if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (do_wr) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = wval[MSTATUS_MIE];
                    mstatus_mpie_d = wval[MSTATUS_MPIE];
                end
                ADDR_MIE:      mie_en_d   = wval[IRQ_BASE +: NUM_IRQ];
                ADDR_MTVEC:    mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0]};
                ADDR_MSCRATCH: mscratch_d = wval;
                ADDR_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_d   = wval;
                ADDR_MTVAL:    mtval_d    = wval;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1_q       <= '0;
            irq_s2_q       <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_en_q       <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            irq_s1_q       <= irq_s1_d;
            irq_s2_q       <= irq_s2_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_en_q       <= mie_en_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (wval),
        .cnt   (mcycle)
    );

    csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instr_retire),
        .wr_lo (ins_wr_lo),
        .wr_hi (ins_wr_hi),
        .wdata (wval),
        .cnt   (minstret)
    );
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset, exception entry, vectored interrupt,
// MRET, CSR set/clear, illegal accesses, counters and coinciding events.
module tb_csr_file;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_retire;
    logic        except;
    logic [4:0]  except_cause;
    logic [31:0] except_pc, except_tval, next_pc;
    logic        mret;
    logic [3:0]  irq;
    logic        trap_take;
    logic [31:0] trap_pc;

    int n_pass  = 0;
    int n_total = 0;

    csr_if #(.XLEN(32)) bus ();

    csr_file #(.XLEN(32), .NUM_IRQ(4), .CNT_WIDTH(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .instr_retire (instr_retire),
        .except       (except),
        .except_cause (except_cause),
        .except_pc    (except_pc),
        .except_tval  (except_tval),
        .next_pc      (next_pc),
        .mret         (mret),
        .irq          (irq),
        .trap_take    (trap_take),
        .trap_pc      (trap_pc)
    );

    always #5 clk = ~clk;

    // Combinational read, no clock edge consumed.
    task automatic rd(input logic [11:0] addr, output logic [31:0] data);
        bus.csr_en   = 1'b1;
        bus.csr_op   = CSR_OP_READ;
        bus.csr_addr = addr;
        #1;
        data = bus.csr_rdata;
        bus.csr_en = 1'b0;
    endtask

    // One CSR instruction committed on the next rising edge.
    task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] old, output logic ill);
        bus.csr_en    = 1'b1;
        bus.csr_op    = op;
        bus.csr_addr  = addr;
        bus.csr_wdata = wd;
        #1;
        old = bus.csr_rdata;
        ill = bus.csr_illegal;
        @(posedge clk); #1;
        bus.csr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        bus.csr_en = 1'b1; bus.csr_op = CSR_OP_READ; bus.csr_addr = ADDR_MSTATUS; bus.csr_wdata = '0;
        except = 1'b1; except_cause = '0; except_pc = 32'h40; except_tval = '0;
        instr_retire = 1'b0; next_pc = '0; mret = 1'b0; irq = '0;
        #12;
        n_total++; if (bus.csr_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", bus.csr_rdata); else n_pass++;
        n_total++; if (trap_take !== 1'b0 || trap_pc !== 32'h0) $display("FAIL rst_trap got %b/%h want 0/0", trap_take, trap_pc); else n_pass++;
        except = 1'b0; bus.csr_en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rd(ADDR_MCYCLE, v);
        n_total++; if (v !== 32'h1) $display("FAIL rst_mcycle got %h want 1", v); else n_pass++;
        rd(ADDR_MSTATUS, v);
        n_total++; if (v !== 32'h1800) $display("FAIL rst_mstatus got %h want 1800", v); else n_pass++;
    endtask

    task automatic test_exception();
        logic [31:0] v; logic ill;
        csr_do(CSR_OP_RW, ADDR_MTVEC, 32'h100, v, ill);
        rd(ADDR_MTVEC, v);
        n_total++; if (v !== 32'h100) $display("FAIL exc_mtvec got %h want 100", v); else n_pass++;
        except = 1'b1; except_cause = EXC_ILLEGAL_INSTR; except_pc = 32'h40; except_tval = 32'hDEAD;
        #1;
        n_total++; if (trap_take !== 1'b1 || trap_pc !== 32'h100) $display("FAIL exc_redirect got %b/%h want 1/100", trap_take, trap_pc); else n_pass++;
        @(posedge clk); #1;
        except = 1'b0;
        rd(ADDR_MEPC, v);
        n_total++; if (v !== 32'h40) $display("FAIL exc_mepc got %h want 40", v); else n_pass++;
        rd(ADDR_MCAUSE, v);
        n_total++; if (v !== 32'h2) $display("FAIL exc_mcause got %h want 2", v); else n_pass++;
        rd(ADDR_MTVAL, v);
        n_total++; if (v !== 32'hDEAD) $display("FAIL exc_mtval got %h want dead", v); else n_pass++;
        rd(ADDR_MSTATUS, v);
        n_total++; if (v !== 32'h1800) $display("FAIL exc_mstatus got %h want 1800", v); else n_pass++;
    endtask

    task automatic test_vectored_irq();
        logic [31:0] v; logic ill;
        @(posedge clk); #1;
        csr_do(CSR_OP_RW, ADDR_MTVEC, 32'h203, v, ill);
        rd(ADDR_MTVEC, v);
        n_total++; if (v !== 32'h201) $display("FAIL irq_mtvec_bit1 got %h want 201", v); else n_pass++;
        @(posedge clk); #1;
        csr_do(CSR_OP_RW, ADDR_MIE, 32'h0001_0000, v, ill);
        csr_do(CSR_OP_RS, ADDR_MSTATUS, 32'h8, v, ill);
        irq = 4'b0001; next_pc = 32'h500; instr_retire = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_total++;
            if (trap_take !== (c == 3)) $display("FAIL irq_take_cycle%0d got %b want %b", c, trap_take, (c == 3));
            else n_pass++;
            if (c == 3) begin
                n_total++; if (trap_pc !== 32'h240) $display("FAIL irq_trap_pc got %h want 240", trap_pc); else n_pass++;
            end
            @(posedge clk); #1;
        end
        instr_retire = 1'b0; irq = '0;
        rd(ADDR_MCAUSE, v);
        n_total++; if (v !== 32'h8000_0010) $display("FAIL irq_mcause got %h want 80000010", v); else n_pass++;
        rd(ADDR_MEPC, v);
        n_total++; if (v !== 32'h500) $display("FAIL irq_mepc got %h want 500", v); else n_pass++;
        rd(ADDR_MTVAL, v);
        n_total++; if (v !== 32'h0) $display("FAIL irq_mtval got %h want 0", v); else n_pass++;
        rd(ADDR_MSTATUS, v);
        n_total++; if (v !== 32'h1880) $display("FAIL irq_mstatus got %h want 1880", v); else n_pass++;
    endtask

    task automatic test_mret();
        logic [31:0] v; logic ill;
        @(posedge clk); #1;
        mret = 1'b1;
        #1;
        n_total++; if (trap_take !== 1'b1 || trap_pc !== 32'h500) $display("FAIL mret_redirect got %b/%h want 1/500", trap_take, trap_pc); else n_pass++;
        @(posedge clk); #1;
        mret = 1'b0;
        rd(ADDR_MSTATUS, v);
        n_total++; if (v !== 32'h1888) $display("FAIL mret_mstatus got %h want 1888", v); else n_pass++;
        @(posedge clk); #1;
        csr_do(CSR_OP_RW, ADDR_MIE, 32'h0, v, ill);
    endtask

    task automatic test_csr_ops();
        logic [31:0] v; logic ill;
        csr_do(CSR_OP_RW, ADDR_MSCRATCH, 32'hF0, v, ill);
        csr_do(CSR_OP_RS, ADDR_MSCRATCH, 32'h0F, v, ill);
        n_total++; if (v !== 32'hF0) $display("FAIL rs_old got %h want f0", v); else n_pass++;
        rd(ADDR_MSCRATCH, v);
        n_total++; if (v !== 32'hFF) $display("FAIL rs_new got %h want ff", v); else n_pass++;
        @(posedge clk); #1;
        csr_do(CSR_OP_RC, ADDR_MSCRATCH, 32'hF0, v, ill);
        rd(ADDR_MSCRATCH, v);
        n_total++; if (v !== 32'h0F) $display("FAIL rc_new got %h want 0f", v); else n_pass++;
        @(posedge clk); #1;
        csr_do(CSR_OP_RS, ADDR_MSCRATCH, 32'h0, v, ill);
        rd(ADDR_MSCRATCH, v);
        n_total++; if (v !== 32'h0F) $display("FAIL rs_zero got %h want 0f", v); else n_pass++;
        @(posedge clk); #1;
        csr_do(CSR_OP_RW, ADDR_MIP, 32'hFFFF_0000, v, ill);
        n_total++; if (ill !== 1'b1) $display("FAIL mip_write_illegal got %b want 1", ill); else n_pass++;
        rd(ADDR_MIP, v);
        n_total++; if (v !== 32'h0) $display("FAIL mip_unchanged got %h want 0", v); else n_pass++;
        n_total++; if (bus.csr_illegal !== 1'b0) $display("FAIL mip_read_legal got %b want 0", bus.csr_illegal); else n_pass++;
        @(posedge clk); #1;
        csr_do(CSR_OP_RW, 12'h7C0, 32'h1, v, ill);
        n_total++; if (ill !== 1'b1) $display("FAIL unknown_addr got %b want 1", ill); else n_pass++;
        csr_do(CSR_OP_RS, 12'hC00, 32'h1, v, ill);
        n_total++; if (ill !== 1'b1) $display("FAIL ro_space got %b want 1", ill); else n_pass++;
        rd(ADDR_MSCRATCH, v);
        n_total++; if (v !== 32'h0F) $display("FAIL illegal_no_state got %h want 0f", v); else n_pass++;
    endtask

    task automatic test_counters();
        logic [31:0] v, h; logic ill;
        @(posedge clk); #1;
        csr_do(CSR_OP_RW, ADDR_MCYCLE, 32'hFFFF_FFFF, v, ill);
        csr_do(CSR_OP_RW, ADDR_MCYCLEH, 32'hFFFF_FFFF, v, ill);
        rd(ADDR_MCYCLE, v);
        rd(ADDR_MCYCLEH, h);
        n_total++; if (v !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFFF) $display("FAIL cnt_allones got %h_%h want ffffffff_ffffffff", h, v); else n_pass++;
        @(posedge clk); #1;
        rd(ADDR_MCYCLE, v);
        rd(ADDR_MCYCLEH, h);
        n_total++; if (v !== 32'h0 || h !== 32'h0) $display("FAIL cnt_wrap got %h_%h want 0_0", h, v); else n_pass++;
        @(posedge clk); #1;
        instr_retire = 1'b1;
        csr_do(CSR_OP_RW, ADDR_MINSTRET, 32'h1234, v, ill);
        instr_retire = 1'b0;
        rd(ADDR_MINSTRET, v);
        n_total++; if (v !== 32'h1234) $display("FAIL minstret_write_wins got %h want 1234", v); else n_pass++;
        rd(ADDR_MINSTRETH, h);
        n_total++; if (h !== 32'h0) $display("FAIL minstreth_hold got %h want 0", h); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        @(posedge clk); #1;
        except = 1'b1; except_cause = EXC_STORE_FAULT; except_pc = 32'h80; except_tval = '0;
        bus.csr_en = 1'b1; bus.csr_op = CSR_OP_RW; bus.csr_addr = ADDR_MSCRATCH; bus.csr_wdata = 32'h55;
        #1;
        n_total++; if (trap_pc !== 32'h200) $display("FAIL vec_exc_pc got %h want 200", trap_pc); else n_pass++;
        @(posedge clk); #1;
        except = 1'b0; bus.csr_en = 1'b0;
        rd(ADDR_MSCRATCH, v);
        n_total++; if (v !== 32'h0F) $display("FAIL except_drops_write got %h want 0f", v); else n_pass++;
        rd(ADDR_MCAUSE, v);
        n_total++; if (v !== 32'h7) $display("FAIL sim_mcause got %h want 7", v); else n_pass++;
    endtask

    task automatic test_reset_mid_trap();
        logic [31:0] v;
        @(posedge clk); #1;
        except = 1'b1; except_cause = EXC_ILLEGAL_INSTR; except_pc = 32'h300;
        bus.csr_en = 1'b1; bus.csr_op = CSR_OP_READ; bus.csr_addr = ADDR_MSTATUS;
        #1;
        n_total++; if (trap_take !== 1'b1) $display("FAIL pre_rst_take got %b want 1", trap_take); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (trap_take !== 1'b0 || trap_pc !== 32'h0) $display("FAIL mid_rst_trap got %b/%h want 0/0", trap_take, trap_pc); else n_pass++;
        n_total++; if (bus.csr_rdata !== 32'h0) $display("FAIL mid_rst_rdata got %h want 0", bus.csr_rdata); else n_pass++;
        bus.csr_op = CSR_OP_RW; bus.csr_addr = ADDR_MIP;
        #1;
        n_total++; if (bus.csr_illegal !== 1'b0) $display("FAIL mid_rst_illegal got %b want 0", bus.csr_illegal); else n_pass++;
        except = 1'b0; bus.csr_en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rd(ADDR_MEPC, v);
        n_total++; if (v !== 32'h0) $display("FAIL trap_lost_mepc got %h want 0", v); else n_pass++;
        rd(ADDR_MCYCLE, v);
        n_total++; if (v !== 32'h1) $display("FAIL rst2_mcycle got %h want 1", v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_exception();
        test_vectored_irq();
        test_mret();
        test_csr_ops();
        test_counters();
        test_simultaneous();
        test_reset_mid_trap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
